// File: rtl/ctrl_pkg.sv
// Shared encodings for the instruction-sequencing controller: FSM states,
// opcodes, branch selects, ALU codes and the one-hot decode class indices.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RALU = 6'b000000;
  localparam logic [5:0] OP_IALU = 6'b000001;
  localparam logic [5:0] OP_LD   = 6'b000010;
  localparam logic [5:0] OP_ST   = 6'b000011;
  localparam logic [5:0] OP_BZ   = 6'b000100;
  localparam logic [5:0] OP_BNZ  = 6'b000101;
  localparam logic [5:0] OP_BLT  = 6'b000110;
  localparam logic [5:0] OP_J    = 6'b000111;
  localparam logic [5:0] OP_CALL = 6'b001000;
  localparam logic [5:0] OP_RET  = 6'b001001;
  localparam logic [5:0] OP_PUSH = 6'b001010;
  localparam logic [5:0] OP_POP  = 6'b001011;
  localparam logic [5:0] OP_MOVE = 6'b001100;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BZ   = 2'b01;
  localparam logic [1:0] BR_BNZ  = 2'b10;
  localparam logic [1:0] BR_BLT  = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  // Bit positions inside the one-hot instruction class vector.
  localparam int C_RALU = 0;
  localparam int C_IALU = 1;
  localparam int C_LD   = 2;
  localparam int C_ST   = 3;
  localparam int C_BZ   = 4;
  localparam int C_BNZ  = 5;
  localparam int C_BLT  = 6;
  localparam int C_J    = 7;
  localparam int C_CALL = 8;
  localparam int C_RET  = 9;
  localparam int C_PUSH = 10;
  localparam int C_POP  = 11;
  localparam int C_MOVE = 12;
  localparam int C_HALT = 13;
  localparam int C_NOP  = 14;
  localparam int NUM_CLS = 15;

  typedef logic [NUM_CLS-1:0] cls_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode to one-hot instruction class. Unknown opcodes fall into the NOP class.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output cls_t       cls
);

  // Pure lookup: exactly one class bit set for any opcode.
  always_comb begin
    cls = '0;
    case (opcode)
      OP_RALU: cls[C_RALU] = 1'b1;
      OP_IALU: cls[C_IALU] = 1'b1;
      OP_LD:   cls[C_LD]   = 1'b1;
      OP_ST:   cls[C_ST]   = 1'b1;
      OP_BZ:   cls[C_BZ]   = 1'b1;
      OP_BNZ:  cls[C_BNZ]  = 1'b1;
      OP_BLT:  cls[C_BLT]  = 1'b1;
      OP_J:    cls[C_J]    = 1'b1;
      OP_CALL: cls[C_CALL] = 1'b1;
      OP_RET:  cls[C_RET]  = 1'b1;
      OP_PUSH: cls[C_PUSH] = 1'b1;
      OP_POP:  cls[C_POP]  = 1'b1;
      OP_MOVE: cls[C_MOVE] = 1'b1;
      OP_HALT: cls[C_HALT] = 1'b1;
      default: cls[C_NOP]  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle instruction controller: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes from (state, IR).
//
//   state  | meaning
//   FETCH  | instruction word being fetched, no strobes
//   DECODE | IM_out captured into IR at the end of this cycle
//   EXEC   | ALU / SP adjust / branch select
//   MEM    | data memory or stack access
//   WB     | register/SP writeback, PC update, retire count
//   HALT   | parked with haltPC until reset
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IM_out,
  output logic             PCUpdate,
  output logic             regDest,
  output logic             writeSP,
  output logic             readSP,
  output logic             updateSP,
  output logic             writeReg,
  output logic             aluSource,
  output logic             PM4,
  output logic             spmmux,
  output logic             retMem,
  output logic             memRead,
  output logic             memWrite,
  output logic             memReg,
  output logic             spmux,
  output logic             moveReg,
  output logic             jump,
  output logic             retPC,
  output logic             haltPC,
  output logic [1:0]       branch,
  output logic [3:0]       aluOp,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  state_t           curState;
  logic [31:0]      ir;
  logic [CNT_W-1:0] instrCnt;
  cls_t             cls;
  logic             unusedBits;

  ctrl_decode uDecode (
    .opcode (ir[31:26]),
    .cls    (cls)
  );

  // Operand fields and the HALT/NOP classes are not needed for strobes.
  assign unusedBits = ^{ir[25:4], cls[C_HALT], cls[C_NOP]};

  assign state       = curState;
  assign instr_count = instrCnt;

  // Sequencer, instruction register and retired-instruction counter.
  // The HALT check looks at IM_out directly because IR is loaded on the
  // same edge that leaves DECODE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      curState <= FETCH;
      ir       <= '0;
      instrCnt <= '0;
    end else begin
      case (curState)
        FETCH:  curState <= DECODE;
        DECODE: begin
          ir       <= IM_out;
          curState <= (IM_out[31:26] == OP_HALT) ? HALT : EXEC;
        end
        EXEC:   curState <= MEM;
        MEM:    curState <= WB;
        WB: begin
          instrCnt <= instrCnt + CNT_W'(1);
          curState <= FETCH;
        end
        HALT:   curState <= HALT;
        default: curState <= FETCH;
      endcase
    end
  end

  // Strobes are decoded combinationally from the current state and IR so a
  // reset clears them immediately.
  always_comb begin
    PCUpdate  = 1'b0;
    regDest   = 1'b0;
    writeSP   = 1'b0;
    readSP    = 1'b0;
    updateSP  = 1'b0;
    writeReg  = 1'b0;
    aluSource = 1'b0;
    PM4       = 1'b0;
    spmmux    = 1'b0;
    retMem    = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    memReg    = 1'b0;
    spmux     = 1'b0;
    moveReg   = 1'b0;
    jump      = 1'b0;
    retPC     = 1'b0;
    haltPC    = 1'b0;
    branch    = BR_NONE;
    aluOp     = ALU_ADD;
    case (curState)
      EXEC: begin
        if (cls[C_RALU]) aluOp = ir[3:0];
        else aluOp = ALU_ADD;
        aluSource = cls[C_IALU] | cls[C_LD] | cls[C_ST];
        spmux     = cls[C_PUSH] | cls[C_POP] | cls[C_CALL] | cls[C_RET];
        PM4       = cls[C_PUSH] | cls[C_CALL];
        if (cls[C_BZ])       branch = BR_BZ;
        else if (cls[C_BNZ]) branch = BR_BNZ;
        else if (cls[C_BLT]) branch = BR_BLT;
        else                 branch = BR_NONE;
      end
      MEM: begin
        memRead  = cls[C_LD] | cls[C_POP] | cls[C_RET];
        memWrite = cls[C_ST] | cls[C_PUSH] | cls[C_CALL];
        retMem   = cls[C_CALL];
        updateSP = cls[C_CALL];
        readSP   = cls[C_PUSH] | cls[C_POP] | cls[C_CALL] | cls[C_RET];
      end
      WB: begin
        PCUpdate = 1'b1;
        writeReg = cls[C_RALU] | cls[C_IALU] | cls[C_LD] | cls[C_POP] | cls[C_MOVE];
        regDest  = cls[C_RALU];
        memReg   = cls[C_LD] | cls[C_POP];
        moveReg  = cls[C_MOVE];
        writeSP  = cls[C_PUSH] | cls[C_POP] | cls[C_CALL] | cls[C_RET];
        jump     = cls[C_J] | cls[C_CALL];
        retPC    = cls[C_RET];
      end
      HALT: haltPC = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm with a 4-bit retire counter so the wrap
// case is reachable in a few dozen instructions.
module tb_control_fsm;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [31:0]      IM_out;
  logic             PCUpdate, regDest, writeSP, readSP, updateSP, writeReg;
  logic             aluSource, PM4, spmmux, retMem, memRead, memWrite;
  logic             memReg, spmux, moveReg, jump, retPC, haltPC;
  logic [1:0]       branch;
  logic [3:0]       aluOp;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .IM_out(IM_out),
    .PCUpdate(PCUpdate), .regDest(regDest), .writeSP(writeSP), .readSP(readSP),
    .updateSP(updateSP), .writeReg(writeReg), .aluSource(aluSource), .PM4(PM4),
    .spmmux(spmmux), .retMem(retMem), .memRead(memRead), .memWrite(memWrite),
    .memReg(memReg), .spmux(spmux), .moveReg(moveReg), .jump(jump),
    .retPC(retPC), .haltPC(haltPC), .branch(branch), .aluOp(aluOp),
    .state(state), .instr_count(instr_count)
  );

  // All strobes packed: bit 23 PCUpdate ... bit 6 haltPC, [5:4] branch, [3:0] aluOp.
  logic [23:0] ctl;
  assign ctl = {PCUpdate, regDest, writeSP, readSP, updateSP, writeReg, aluSource,
                PM4, spmmux, retMem, memRead, memWrite, memReg, spmux, moveReg,
                jump, retPC, haltPC, branch, aluOp};

  localparam logic [23:0] M_PCU  = 24'h800000;
  localparam logic [23:0] M_RDST = 24'h400000;
  localparam logic [23:0] M_WSP  = 24'h200000;
  localparam logic [23:0] M_RSP  = 24'h100000;
  localparam logic [23:0] M_USP  = 24'h080000;
  localparam logic [23:0] M_WREG = 24'h040000;
  localparam logic [23:0] M_ASRC = 24'h020000;
  localparam logic [23:0] M_PM4  = 24'h010000;
  localparam logic [23:0] M_RMEM = 24'h004000;
  localparam logic [23:0] M_MRD  = 24'h002000;
  localparam logic [23:0] M_MWR  = 24'h001000;
  localparam logic [23:0] M_MREG = 24'h000800;
  localparam logic [23:0] M_SPMX = 24'h000400;
  localparam logic [23:0] M_MOVE = 24'h000200;
  localparam logic [23:0] M_JMP  = 24'h000100;
  localparam logic [23:0] M_RPC  = 24'h000080;
  localparam logic [23:0] M_HALT = 24'h000040;
  localparam logic [23:0] M_BLT  = 24'h000030;
  localparam logic [23:0] M_BZ   = 24'h000010;

  localparam logic [31:0] W_RALU = 32'h0000_0002;  // func 0010
  localparam logic [31:0] W_LD   = 32'h0800_0000;
  localparam logic [31:0] W_ST   = 32'h0C00_0000;
  localparam logic [31:0] W_BZ   = 32'h1000_0000;
  localparam logic [31:0] W_BLT  = 32'h1800_0000;
  localparam logic [31:0] W_CALL = 32'h2000_0000;
  localparam logic [31:0] W_RET  = 32'h2400_0000;
  localparam logic [31:0] W_PUSH = 32'h2800_0000;
  localparam logic [31:0] W_MOVE = 32'h3000_0000;
  localparam logic [31:0] W_NOP  = 32'h5400_0007;  // opcode 010101
  localparam logic [31:0] W_HALT = 32'hFC00_0000;

  int nChecks = 0;
  int nFail   = 0;
  int expCnt  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one non-HALT instruction from FETCH back to FETCH. IM_out is
  // scrambled after DECODE to show IR alone drives the later strobes.
  task automatic runInstr(input string name, input logic [31:0] w,
                          input logic [23:0] exE, input logic [23:0] meE,
                          input logic [23:0] wbE);
    IM_out = w;
    chk({name, "_fetch_state"}, 32'(state), 32'd0);
    chk({name, "_fetch_ctl"}, 32'(ctl), 32'd0);
    tick();
    chk({name, "_decode_state"}, 32'(state), 32'd1);
    chk({name, "_decode_ctl"}, 32'(ctl), 32'd0);
    tick();
    IM_out = W_HALT;
    #1;
    chk({name, "_exec_state"}, 32'(state), 32'd2);
    chk({name, "_exec_ctl"}, 32'(ctl), 32'(exE));
    tick();
    chk({name, "_mem_state"}, 32'(state), 32'd3);
    chk({name, "_mem_ctl"}, 32'(ctl), 32'(meE));
    tick();
    chk({name, "_wb_state"}, 32'(state), 32'd4);
    chk({name, "_wb_ctl"}, 32'(ctl), 32'(wbE | M_PCU));
    tick();
    expCnt = (expCnt + 1) % 16;
    chk({name, "_count"}, 32'(instr_count), 32'(expCnt));
  endtask

  initial begin
    reset  = 1'b0;
    IM_out = W_RALU;
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctl", 32'(ctl), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    runInstr("ralu", W_RALU, 24'h000002, 24'h0, M_WREG | M_RDST);
    runInstr("ld",   W_LD,   M_ASRC, M_MRD, M_WREG | M_MREG);
    runInstr("st",   W_ST,   M_ASRC, M_MWR, 24'h0);
    chk("ldst_count2", 32'(instr_count), 32'd3);
    runInstr("call", W_CALL, M_SPMX | M_PM4, M_MWR | M_RMEM | M_USP | M_RSP, M_JMP | M_WSP);
    runInstr("ret",  W_RET,  M_SPMX, M_MRD | M_RSP, M_RPC | M_WSP);
    runInstr("push", W_PUSH, M_SPMX | M_PM4, M_MWR | M_RSP, M_WSP);
    runInstr("bz",   W_BZ,   M_BZ, 24'h0, 24'h0);
    runInstr("blt",  W_BLT,  M_BLT, 24'h0, 24'h0);
    runInstr("move", W_MOVE, 24'h0, 24'h0, M_WREG | M_MOVE);

    // Asynchronous reset in the MEM cycle of a store.
    IM_out = W_ST;
    tick(); tick(); tick();
    chk("st_mem_write", 32'(memWrite), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_memwrite", 32'(memWrite), 32'd0);
    chk("async_state", 32'(state), 32'd0);
    chk("async_count", 32'(instr_count), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    expCnt = 0;
    chk("post_rst_state", 32'(state), 32'd0);

    // Counter wrap: 15 NOPs bring it to all-ones, the 16th wraps to zero.
    for (int i = 0; i < 15; i++) runInstr("nop", W_NOP, 24'h0, 24'h0, 24'h0);
    chk("cnt_max", 32'(instr_count), 32'd15);
    runInstr("nop_wrap", W_NOP, 24'h0, 24'h0, 24'h0);
    chk("cnt_wrap", 32'(instr_count), 32'd0);

    // HALT: parked from the third cycle, count frozen.
    IM_out = W_HALT;
    chk("halt_fetch", 32'(state), 32'd0);
    tick();
    chk("halt_decode", 32'(state), 32'd1);
    tick();
    chk("halt_enter_state", 32'(state), 32'd5);
    chk("halt_enter_ctl", 32'(ctl), 32'(M_HALT));
    IM_out = W_RALU;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_hold_state", 32'(state), 32'd5);
      chk("halt_hold_ctl", 32'(ctl), 32'(M_HALT));
    end
    chk("halt_count", 32'(instr_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter: CNT_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 IM_out  input  32  current instruction word from the datapath: opcode [31:26], ALU func [3:0].
REQ-005 PCUpdate, regDest, writeSP, readSP, updateSP, writeReg, aluSource, PM4, spmmux, retMem, memRead, memWrite, memReg, spmux, moveReg, jump, retPC, haltPC  output  1 each  datapath control strobes.
REQ-006 branch  output  2  branch condition select: 00 none, 01 BZ, 10 BNZ, 11 BLT.
REQ-007 aluOp  output  4  ALU function select.
REQ-008 state  output  3  current FSM state, for debug.
REQ-009 instr_count  output  CNT_W  count of retired instructions.

Function
REQ-010 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, with one state per cycle in the sequence FETCH->DECODE->EXEC->MEM->WB->FETCH.
REQ-011 In DECODE, the block SHALL latch IM_out into an internal 32-bit IR; all later decoding in the instruction SHALL use IR only.
REQ-012 Opcodes SHALL be: 000000 R-ALU, 000001 I-ALU, 000010 LD, 000011 ST, 000100 BZ, 000101 BNZ, 000110 BLT, 000111 J, 001000 CALL, 001001 RET, 001010 PUSH, 001011 POP, 001100 MOVE, 111111 HALT; any other opcode SHALL be a NOP.
REQ-013 Outputs SHALL be combinational from (state, IR); every strobe not listed for a state SHALL be 0.
REQ-014 EXEC: aluOp = IR[3:0] for R-ALU, 0000 (add) for I-ALU/LD/ST/branches; aluSource = 1 for I-ALU/LD/ST; spmux = 1 for PUSH/POP/CALL/RET, with PM4 = 1 (-1) for PUSH/CALL; branch = 01/10/11 for BZ/BNZ/BLT.
REQ-015 MEM: memRead = 1 for LD/POP/RET; memWrite = 1 for ST/PUSH/CALL; retMem = 1 and updateSP = 1 for CALL; readSP = 1 for PUSH/POP/CALL/RET.
REQ-016 WB: writeReg = 1 for R-ALU/I-ALU/LD/POP/MOVE; regDest = 1 for R-ALU only; memReg = 1 for LD/POP; moveReg = 1 for MOVE; writeSP = 1 for PUSH/POP/CALL/RET; jump = 1 for J/CALL; retPC = 1 for RET.
REQ-017 PCUpdate SHALL pulse exactly one cycle, in WB, for every non-HALT instruction, including NOPs; instr_count SHALL increment by 1 in that same cycle and wrap from 2^CNT_W-1 to 0.
REQ-018 A HALT IR in DECODE SHALL move the FSM to HALT on the next edge; in HALT, haltPC = 1 and PCUpdate = 0, with all other strobes 0, until reset; instr_count SHALL NOT increment for HALT.
REQ-019 IM_out changes outside DECODE SHALL have no effect on outputs.

Reset
REQ-020 While reset = 0: state = FETCH, IR = 0, instr_count = 0, and all outputs 0; this SHALL take effect immediately, even mid-instruction.
REQ-021 After reset deassertion, the first state SHALL be FETCH, and the first PCUpdate SHALL occur 4 cycles after the first rising edge.

Structure
REQ-022 The package ctrl_pkg SHALL hold the state encodings, opcode constants, branch codes and the ALU add code.
REQ-023 Opcode-to-class decoding SHALL live in one combinational sub-module, ctrl_decode (IR[31:26] -> one-hot class vector); control_fsm instantiates it once.

Verification
REQ-024 Release reset, IM_out = R-ALU with func 0010 -> state sequence 0,1,2,3,4; aluOp = 0010 in EXEC; writeReg = 1 and regDest = 1 in WB; PCUpdate 1 only in WB; instr_count = 1.
REQ-025 LD then ST -> memRead = 1 only in LD's MEM, memWrite = 1 only in ST's MEM; memReg = 1 in LD's WB; instr_count = 2 after 10 cycles.
REQ-026 CALL -> EXEC: spmux = 1, PM4 = 1; MEM: memWrite = 1, retMem = 1, updateSP = 1; WB: jump = 1, writeSP = 1; then RET -> WB: retPC = 1.
REQ-027 HALT -> state = 5 from the 3rd cycle onward, with haltPC = 1 and PCUpdate = 0 held for 20 cycles; instr_count unchanged.
REQ-028 Assert reset = 0 in MEM of a ST -> memWrite drops to 0 asynchronously; after release, state = 0 and instr_count = 0.
REQ-029 Preload instr_count = 2^CNT_W-1 (CNT_W = 4, count 15), run one NOP -> instr_count = 0, with PCUpdate pulsing once.
